// File: rtl/ysyx_22041412_pkg.sv
// Shared types for the ysyx_22041412 PC unit: decoder classes, branch
// func3 codes, FSM states and a small class helper.
// Optional feature macro: YSYX_22041412_PCU_TRAP_EN (adds the HALT state).
package ysyx_22041412_pkg;

   typedef enum logic [3:0] {
      DT_R      = 4'b0000,
      DT_I      = 4'b0001,
      DT_AUIPC  = 4'b0010,
      DT_BRANCH = 4'b0011,
      DT_STORE  = 4'b0100,
      DT_LOAD   = 4'b1001,
      DT_JAL    = 4'b1011,
      DT_JALR   = 4'b1100,
      DT_MUL    = 4'b1111
   } dec_type_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

`ifdef YSYX_22041412_PCU_TRAP_EN
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_e;
`else
   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
   } state_e;
`endif

   function automatic logic is_mem_type(input logic [3:0] t);
      return (t == DT_LOAD) || (t == DT_STORE);
   endfunction

endpackage

// File: rtl/ysyx_22041412_pcu_if.sv
// Bundle between the PC unit and fetch/decode/regfile/mul/lsu.
// master = PC unit side, slave = environment side. XLEN = PC width.
interface ysyx_22041412_pcu_if #(
   parameter int XLEN = 64
);
   logic            ifu_req;
   logic [XLEN-1:0] ifu_addr;
   logic            ifu_valid;
   logic [31:0]     ifu_inst;
   logic [31:0]     inst;
   logic [3:0]      dec_type;
   logic [2:0]      dec_func3;
   logic [XLEN-1:0] dec_imm;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            mul_req;
   logic            mul_done;
   logic            lsu_req;
   logic            lsu_done;
   logic            reg_wen;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] npc;
   logic            commit;
   logic            trap;

   modport master (
      output ifu_req, ifu_addr, inst,
      output mul_req, lsu_req,
      output reg_wen, pc, npc, commit, trap,
      input  ifu_valid, ifu_inst,
      input  dec_type, dec_func3, dec_imm,
      input  rs1_data, rs2_data,
      input  mul_done, lsu_done
   );

   modport slave (
      input  ifu_req, ifu_addr, inst,
      input  mul_req, lsu_req,
      input  reg_wen, pc, npc, commit, trap,
      output ifu_valid, ifu_inst,
      output dec_type, dec_func3, dec_imm,
      output rs1_data, rs2_data,
      output mul_done, lsu_done
   );

endinterface

// File: rtl/ysyx_22041412_bcmp.sv
// Combinational branch comparator.
// Ports: rs1_i/rs2_i operands, func3_i branch kind, taken_o decision.
module ysyx_22041412_bcmp
   import ysyx_22041412_pkg::*;
#(
   parameter int XLEN = 64
)(
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [2:0]      func3_i,
   output logic            taken_o
);

   logic eq;
   logic lt;
   logic ltu;

   assign eq  = (rs1_i == rs2_i);
   assign lt  = ($signed(rs1_i) < $signed(rs2_i));
   assign ltu = (rs1_i < rs2_i);

   always_comb begin
      taken_o = 1'b0;
      unique case (func3_i)
         F3_BEQ:  taken_o = eq;
         F3_BNE:  taken_o = !eq;
         F3_BLT:  taken_o = lt;
         F3_BGE:  taken_o = !lt;
         F3_BLTU: taken_o = ltu;
         F3_BGEU: taken_o = !ltu;
         // 010/011 are not branch kinds; never taken
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/ysyx_22041412_pcu.sv
// Multi-cycle PC unit: FETCH -> DECODE -> EXEC -> [MEM] -> WB sequencer.
// Ports: clk, rst (sync, active-high), bus (ysyx_22041412_pcu_if.master).
// Macro YSYX_22041412_PCU_TRAP_EN: misaligned redirect traps and halts.
module ysyx_22041412_pcu
   import ysyx_22041412_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
)(
   input  logic                       clk,
   input  logic                       rst,
   ysyx_22041412_pcu_if.master        bus
);

   localparam logic [XLEN-1:0] STEP = XLEN'(4);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] npc_q, npc_d;
   logic [31:0]     inst_q, inst_d;

   logic            taken;
   logic            redir;
   logic [XLEN-1:0] tgt;
   logic [XLEN-1:0] jalr_sum;
   logic [3:0]      dtype;

   logic            ifu_req_w;
   logic            mul_req_w;
   logic            lsu_req_w;
   logic            commit_w;
   logic            reg_wen_w;
   logic            trap_w;

`ifdef YSYX_22041412_PCU_TRAP_EN
   logic            mis_q, mis_d;
`endif

   assign dtype    = bus.dec_type;
   assign jalr_sum = bus.rs1_data + bus.dec_imm;

   ysyx_22041412_bcmp #(
      .XLEN (XLEN)
   ) u_bcmp (
      .rs1_i   (bus.rs1_data),
      .rs2_i   (bus.rs2_data),
      .func3_i (bus.dec_func3),
      .taken_o (taken)
   );

   // Target for the current instruction; only consumed in EXEC.
   always_comb begin
      redir = 1'b0;
      tgt   = pc_q + STEP;
      unique case (1'b1)
         (dtype == DT_BRANCH) && taken: begin
            redir = 1'b1;
            tgt   = pc_q + bus.dec_imm;
         end
         (dtype == DT_JAL): begin
            redir = 1'b1;
            tgt   = pc_q + bus.dec_imm;
         end
         (dtype == DT_JALR): begin
            redir = 1'b1;
            tgt   = {jalr_sum[XLEN-1:1], 1'b0};
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      npc_d     = npc_q;
      inst_d    = inst_q;
      ifu_req_w = 1'b0;
      mul_req_w = 1'b0;
      lsu_req_w = 1'b0;
      commit_w  = 1'b0;
      reg_wen_w = 1'b0;
      trap_w    = 1'b0;
`ifdef YSYX_22041412_PCU_TRAP_EN
      mis_d     = mis_q;
`endif
      unique case (state_q)
         S_FETCH: begin
            ifu_req_w = 1'b1;
            if (bus.ifu_valid) begin
               inst_d  = bus.ifu_inst;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            npc_d = tgt;
`ifdef YSYX_22041412_PCU_TRAP_EN
            mis_d = redir && (tgt[1:0] != 2'b00);
`endif
            if (dtype == DT_MUL) begin
               mul_req_w = 1'b1;
               if (bus.mul_done) state_d = S_WB;
            end else if (is_mem_type(dtype)) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            lsu_req_w = 1'b1;
            if (bus.lsu_done) state_d = S_WB;
         end
         S_WB: begin
`ifdef YSYX_22041412_PCU_TRAP_EN
            if (mis_q) begin
               trap_w  = 1'b1;
               state_d = S_HALT;
            end else begin
               commit_w  = 1'b1;
               reg_wen_w = (dtype != DT_STORE) &&
                           (dtype != DT_BRANCH);
               pc_d      = npc_q;
               state_d   = S_FETCH;
            end
`else
            commit_w  = 1'b1;
            reg_wen_w = (dtype != DT_STORE) &&
                        (dtype != DT_BRANCH);
            pc_d      = npc_q;
            state_d   = S_FETCH;
`endif
         end
`ifdef YSYX_22041412_PCU_TRAP_EN
         S_HALT: trap_w = 1'b1;
`endif
         default: state_d = S_FETCH;
      endcase
      // Reset aborts whatever is in flight: no request, commit or write
      // may escape in the cycle that rst is sampled.
      if (rst) begin
         ifu_req_w = 1'b0;
         mul_req_w = 1'b0;
         lsu_req_w = 1'b0;
         commit_w  = 1'b0;
         reg_wen_w = 1'b0;
         trap_w    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         npc_q   <= RESET_PC + STEP;
         inst_q  <= '0;
`ifdef YSYX_22041412_PCU_TRAP_EN
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         npc_q   <= npc_d;
         inst_q  <= inst_d;
`ifdef YSYX_22041412_PCU_TRAP_EN
         mis_q   <= mis_d;
`endif
      end
   end

   assign bus.ifu_req  = ifu_req_w;
   assign bus.ifu_addr = pc_q;
   assign bus.inst     = inst_q;
   assign bus.mul_req  = mul_req_w;
   assign bus.lsu_req  = lsu_req_w;
   assign bus.reg_wen  = reg_wen_w;
   assign bus.pc       = pc_q;
   assign bus.npc      = npc_q;
   assign bus.commit   = commit_w;
   assign bus.trap     = trap_w;

endmodule

// File: tb/tb_ysyx_22041412_pcu.sv
// Bench for ysyx_22041412_pcu: directed instruction stream against a
// timeline model of the sequencer, plus literal target checks.
module tb_ysyx_22041412_pcu;
   import ysyx_22041412_pkg::*;

   localparam int          XLEN = 64;
   localparam logic [63:0] RPC  = 64'h8000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ysyx_22041412_pcu_if #(.XLEN(XLEN)) bus();

   ysyx_22041412_pcu #(
      .XLEN     (XLEN),
      .RESET_PC (RPC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int n_inst   = 0;

   // expectations for the current cycle
   logic        e_on = 1'b0;
   logic        e_rst, e_ifu, e_mul, e_lsu, e_com, e_wen, e_trap;
   logic        e_npc_on, e_inst_on;
   logic [63:0] e_pc, e_npc;
   logic [31:0] e_inst;
   logic [63:0] m_pc;
   bit          first_chk;

   task automatic chk(input string n, input logic [63:0] a,
                      input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, a, e);
      end
   endtask

   task automatic chk1(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      if (e_on) begin
         chk1("ifu_req", bus.ifu_req, e_ifu);
         chk1("mul_req", bus.mul_req, e_mul);
         chk1("lsu_req", bus.lsu_req, e_lsu);
         chk1("commit", bus.commit, e_com);
         chk1("reg_wen", bus.reg_wen, e_wen);
         chk1("trap", bus.trap, e_trap);
         chk1("req_excl", $countones({bus.ifu_req, bus.mul_req,
                                      bus.lsu_req}) <= 1, 1'b1);
         if (!e_rst) begin
            chk("pc", bus.pc, e_pc);
            if (e_ifu) chk("ifu_addr", bus.ifu_addr, e_pc);
            if (e_npc_on) chk("npc", bus.npc, e_npc);
            if (e_inst_on) chk("inst", {32'd0, bus.inst}, {32'd0, e_inst});
         end
      end
   end

   task automatic idle_in();
      bus.ifu_valid = 1'b0;
      bus.ifu_inst  = 32'h0;
      bus.mul_done  = 1'b0;
      bus.lsu_done  = 1'b0;
   endtask

   task automatic clr_exp();
      e_on      = 1'b1;
      e_rst     = 1'b0;
      e_ifu     = 1'b0;
      e_mul     = 1'b0;
      e_lsu     = 1'b0;
      e_com     = 1'b0;
      e_wen     = 1'b0;
      e_trap    = 1'b0;
      e_npc_on  = 1'b0;
      e_inst_on = 1'b0;
      e_pc      = m_pc;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_in();
      clr_exp();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle_in();
      clr_exp();
      e_rst = 1'b1;
      @(posedge clk);
      #4;
      chk("rst_pc", bus.pc, RPC);
      chk("rst_npc", bus.npc, 64'h8000_0004);
      chk("rst_inst", {32'd0, bus.inst}, 64'd0);
      m_pc      = RPC;
      first_chk = 1'b1;
   endtask

   task automatic run(input logic [3:0] ty, input logic [2:0] f3,
                      input logic [63:0] imm, input logic [63:0] r1,
                      input logic [63:0] r2, input int fw, input int xw,
                      input int mw, input bit abrt, input bit lit_on,
                      input logic [63:0] lit, output int len);
      logic [63:0] mn;
      logic [31:0] iw;
      bit tk, ldst, wen, trp, mul;
      n_inst++;
      iw = 32'h1000_0000 + 32'(n_inst);
      tk = 1'b0;
      mn = m_pc + 64'd4;
      if (ty == DT_BRANCH) begin
         case (f3)
            3'b000:  tk = (r1 == r2);
            3'b001:  tk = (r1 != r2);
            3'b100:  tk = ($signed(r1) < $signed(r2));
            3'b101:  tk = ($signed(r1) >= $signed(r2));
            3'b110:  tk = (r1 < r2);
            3'b111:  tk = (r1 >= r2);
            default: tk = 1'b0;
         endcase
         if (tk) mn = m_pc + imm;
      end else if (ty == DT_JAL) begin
         tk = 1'b1;
         mn = m_pc + imm;
      end else if (ty == DT_JALR) begin
         tk = 1'b1;
         mn = (r1 + imm) & ~64'd1;
      end
      mul  = (ty == DT_MUL);
      ldst = (ty == DT_LOAD) || (ty == DT_STORE);
      wen  = !((ty == DT_STORE) || (ty == DT_BRANCH));
`ifdef YSYX_22041412_PCU_TRAP_EN
      trp  = tk && (mn[1:0] != 2'b00);
`else
      trp  = 1'b0;
`endif
      len = (fw + 1) + 1 + (mul ? xw + 1 : 1) + (ldst ? mw + 1 : 0) + 1;
      for (int i = 0; i <= fw; i++) begin
         cyc();
         if (i == 0) begin
            bus.dec_type  = ty;
            bus.dec_func3 = f3;
            bus.dec_imm   = imm;
            bus.rs1_data  = r1;
            bus.rs2_data  = r2;
         end
         e_ifu         = 1'b1;
         bus.ifu_valid = (i == fw);
         bus.ifu_inst  = (i == fw) ? iw : 32'hDEAD_BEEF;
         if (i == 0 && first_chk) begin
            #3;
            chk("first_ifu_addr", bus.ifu_addr, 64'h8000_0000);
            chk1("first_ifu_req", bus.ifu_req, 1'b1);
            first_chk = 1'b0;
         end
      end
      cyc();
      e_inst_on    = 1'b1;
      e_inst       = iw;
      bus.mul_done = 1'b1;
      bus.lsu_done = 1'b1;
      for (int i = 0; i < (mul ? xw + 1 : 1); i++) begin
         cyc();
         e_inst_on    = 1'b1;
         e_inst       = iw;
         e_mul        = mul;
         bus.mul_done = mul && (i == xw);
         bus.lsu_done = 1'b1;
      end
      if (ldst) begin
         for (int i = 0; i <= mw; i++) begin
            cyc();
            e_inst_on = 1'b1;
            e_inst    = iw;
            if (abrt) begin
               rst          = 1'b1;
               bus.lsu_done = 1'b1;
               e_rst        = 1'b1;
               m_pc         = RPC;
               first_chk    = 1'b1;
               return;
            end
            e_lsu        = 1'b1;
            bus.lsu_done = (i == mw);
            bus.mul_done = 1'b1;
         end
      end
      cyc();
      e_inst_on = 1'b1;
      e_inst    = iw;
      e_npc_on  = 1'b1;
      e_npc     = mn;
      e_trap    = trp;
      e_com     = !trp;
      e_wen     = wen && !trp;
      if (lit_on) begin
         #3;
         chk("lit_npc", bus.npc, lit);
      end
      if (trp) begin
         for (int i = 0; i < 4; i++) begin
            cyc();
            e_trap        = 1'b1;
            bus.ifu_valid = 1'b1;
         end
         do_reset();
      end else begin
         m_pc = mn;
      end
   endtask

   initial begin
      int len;
      bus.dec_type  = 4'h0;
      bus.dec_func3 = 3'h0;
      bus.dec_imm   = 64'h0;
      bus.rs1_data  = 64'h0;
      bus.rs2_data  = 64'h0;
      idle_in();
      m_pc      = RPC;
      first_chk = 1'b0;
      do_reset();

      run(DT_I, 3'd0, 64'd4, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0004, len);
      chk("alu_len", 64'(len), 64'd4);
      run(DT_I, 3'd0, 64'd4, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0008, len);
      run(DT_I, 3'd0, 64'd1, 64'd0, 64'd0, 0, 0, 0, 0, 0, 0, len);
      run(DT_I, 3'd0, 64'd1, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0010, len);
      run(DT_BRANCH, 3'b100, -64'sd8, 64'd1, ONES, 0, 0, 0, 0, 1,
          64'h8000_0014, len);
      run(DT_JAL, 3'd0, -64'sd4, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0010, len);
      run(DT_BRANCH, 3'b110, -64'sd8, 64'd1, ONES, 0, 0, 0, 0, 1,
          64'h8000_0008, len);
      run(DT_BRANCH, 3'b000, 64'h20, 64'd5, 64'd5, 2, 0, 0, 0, 1,
          64'h8000_0028, len);
      run(DT_BRANCH, 3'b001, 64'h20, 64'd5, 64'd5, 0, 0, 0, 0, 1,
          64'h8000_002C, len);
      run(DT_BRANCH, 3'b010, 64'h40, 64'd1, 64'd2, 0, 0, 0, 0, 1,
          64'h8000_0030, len);
      run(DT_BRANCH, 3'b101, 64'h10, ONES, 64'd1, 0, 0, 0, 0, 1,
          64'h8000_0034, len);
      run(DT_BRANCH, 3'b111, 64'h10, ONES, 64'd1, 0, 0, 0, 0, 1,
          64'h8000_0044, len);
      run(DT_STORE, 3'd0, 64'd8, 64'd0, 64'd0, 1, 0, 0, 0, 1,
          64'h8000_0048, len);
      chk("store_len", 64'(len), 64'd6);
      run(DT_LOAD, 3'd0, 64'd8, 64'd0, 64'd0, 0, 0, 3, 0, 1,
          64'h8000_004C, len);
      chk("load_len", 64'(len), 64'd8);
      run(DT_JALR, 3'd0, 64'd4, 64'h8000_1001, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_1004, len);
      run(DT_MUL, 3'd0, 64'd0, 64'd3, 64'd7, 0, 3, 0, 0, 1,
          64'h8000_1008, len);
      chk("mul_len", 64'(len), 64'd7);
      run(DT_MUL, 3'd0, 64'd0, 64'd3, 64'd7, 0, 0, 0, 0, 0, 0, len);
      run(DT_JALR, 3'd0, 64'd4, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0,
          0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, len);
      run(DT_I, 3'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 1, 64'd0, len);
      run(DT_LOAD, 3'd0, 64'd0, 64'd0, 64'd0, 0, 0, 2, 1, 0, 0, len);
      run(DT_I, 3'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0004, len);
      run(DT_AUIPC, 3'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 0, 0, len);
      run(DT_R, 3'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_000C, len);
      run(DT_JAL, 3'd0, 64'd6, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0012, len);
`ifdef YSYX_22041412_PCU_TRAP_EN
      run(DT_I, 3'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0004, len);
`else
      run(DT_I, 3'd0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 0, 1,
          64'h8000_0016, len);
`endif
      @(posedge clk);
      #1;
      e_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ysyx_22041412_pcu.md
YSYX_22041412_PCU -- requirements
Module: ysyx_22041412_pcu

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath/PC width.
REQ-002 SHALL have parameter RESET_PC, default 'h80000000, PC value after reset.
REQ-003 SHALL have ports clk in 1 (sole clock) and rst in 1 (synchronous, active-high reset).
REQ-004 SHALL have ifu_req out 1 (fetch request), ifu_addr out XLEN (fetch address), ifu_valid in 1 (fetch data valid), ifu_inst in 32 (fetched instruction).
REQ-005 SHALL have inst out 32 (latched instruction to decoder), dec_type in 4 (instruction class), dec_func3 in 3, dec_imm in XLEN (sign-extended immediate).
REQ-006 SHALL have rs1_data in XLEN and rs2_data in XLEN (register file read data).
REQ-007 SHALL have mul_req out 1, mul_done in 1, lsu_req out 1, lsu_done in 1 (multiplier/memory handshakes).
REQ-008 SHALL have reg_wen out 1, pc out XLEN, npc out XLEN, commit out 1 (difftest pulse), trap out 1.

Function
REQ-009 SHALL sequence states FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH; MEM only for dec_type LOAD or STORE.
REQ-010 FETCH: ifu_req=1, ifu_addr=pc; on ifu_valid latch ifu_inst into inst and go DECODE; otherwise stay, ifu_req held.
REQ-011 DECODE: one cycle; decoder outputs and rs1/rs2 are stable from end of DECODE.
REQ-012 EXEC: compute npc; for MUL hold mul_req=1 until mul_done (sampled same cycle, zero-wait allowed); other classes leave after one cycle.
REQ-013 MEM: lsu_req=1 held until lsu_done; same-cycle completion allowed.
REQ-014 WB: commit=1 and pc<=npc for exactly one cycle; reg_wen=1 for one cycle unless dec_type is STORE or BRANCH.
REQ-015 Minimum latency: 4 cycles/instruction (ALU, branch, jump), 5 cycles (load/store), each wait cycle adds one.
REQ-016 npc default = pc+4, XLEN-bit wrap-around.
REQ-017 BRANCH: func3 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu; taken -> npc=pc+dec_imm; 010/011 never taken.
REQ-018 JAL: npc=pc+dec_imm; JALR: npc=(rs1_data+dec_imm) with bit0 cleared.
REQ-019 npc and branch decision SHALL be registered at end of EXEC; pc and npc outputs stable throughout WB.
REQ-020 inst SHALL hold its value from DECODE until next FETCH completion.
REQ-021 mul_done/lsu_done outside their wait states SHALL be ignored.
REQ-022 At most one of ifu_req, mul_req, lsu_req SHALL be high in any cycle.

Reset
REQ-023 On rst: state=FETCH, pc=RESET_PC, npc=RESET_PC+4, inst=0, all req/reg_wen/commit/trap = 0.
REQ-024 rst mid-operation (any state, any pending handshake) SHALL abort next edge; no commit, no reg_wen.
REQ-025 First ifu_req SHALL be in the first cycle after rst deasserts.

Configuration
REQ-026 Macro YSYX_22041412_PCU_TRAP_EN defined: taken branch/jump with npc[1:0]!=0 -> trap=1 in WB instead of commit, no reg_wen, pc unchanged, enter HALT (trap held) until rst.
REQ-027 Macro undefined: no HALT state, trap tied 0, misaligned target committed as computed.

Structure
REQ-028 Shared package ysyx_22041412_pkg SHALL hold dec_type encodings (R 0000, I 0001, AUIPC 0010, BRANCH 0011, STORE 0100, LOAD 1001, JAL 1011, JALR 1100, MUL 1111), func3 branch codes, state enum.
REQ-029 Sub-module ysyx_22041412_bcmp (combinational branch comparator: rs1, rs2, func3 -> taken) SHALL be instantiated once.

Verification
REQ-030 Reset, ifu_valid tied 1, addi stream -> ifu_addr 0x80000000, 0x80000004, 0x80000008 every 4 cycles, commit each 4th cycle.
REQ-031 bltu rs1=1, rs2=0xFFFF_FFFF_FFFF_FFFF, imm=-8, pc=0x80000010 -> npc=0x80000008; same operands blt -> npc=0x80000014.
REQ-032 Load, lsu_done after 3 wait cycles -> lsu_req high 4 cycles, commit 8 cycles after FETCH start, reg_wen 1 pulse.
REQ-033 JALR rs1=0x80001001, imm=4 -> npc=0x80001004, reg_wen=1; MUL with mul_done at cycle 6 -> no req overlap.
REQ-034 rst asserted during MEM with lsu_done pending -> next cycle FETCH, ifu_addr=0x80000000, no commit.
REQ-035 With TRAP_EN, JAL imm=6 -> trap=1, commit=0, ifu_req stays 0 until rst; without, npc=pc+6 committed.
